// File: rtl/signed_result_formatter_if.sv
// Handshake and result bundle between the multiplier core, the sign/BCD
// formatter and the display driver.
interface signed_result_formatter_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [WIDTH-1:0]      magnitude;
   logic                  sign;
   logic                  busy;
   logic                  done;
   logic [WIDTH:0]        signedResult;
   logic                  negative;
   logic [4*DIGITS-1:0]   bcd;

   modport master (
      output start, magnitude, sign,
      input  busy, done, signedResult, negative, bcd
   );

   modport slave (
      input  start, magnitude, sign,
      output busy, done, signedResult, negative, bcd
   );
endinterface

// File: rtl/signed_result_formatter.sv
// Restores the sign to an unsigned product magnitude and converts the magnitude
// to BCD digits with a sequential shift-add-3 (double-dabble) loop.
module signed_result_formatter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input logic                      clk,
   input logic                      rst_n,
   signed_result_formatter_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t                stateReg;
   state_t                stateNext;

   logic                  captureEn;
   logic                  shiftEn;
   logic                  finishEn;

   logic [WIDTH-1:0]      magReg;
   logic                  signReg;
   logic [WIDTH-1:0]      shReg;
   logic [4*DIGITS-1:0]   digitAcc;
   logic [4*DIGITS-1:0]   adjusted;
   logic [CW-1:0]         iterCnt;

   logic                  effSign;
   logic [WIDTH:0]        zeroExt;

   logic                  doneReg;
   logic [WIDTH:0]        resultReg;
   logic                  negReg;
   logic [4*DIGITS-1:0]   bcdReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      captureEn = 1'b0;
      shiftEn   = 1'b0;
      finishEn  = 1'b0;
      case (stateReg)
         IDLE: begin
            if (bus.start) begin
               captureEn = 1'b1;
               stateNext = SHIFT;
            end
         end
         SHIFT: begin
            shiftEn = 1'b1;
            if (iterCnt == CW'(WIDTH - 1)) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            finishEn  = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Add-3 correction: any digit that would overflow past 9 after doubling is pre-biased.
   always_comb begin
      adjusted = digitAcc;
      for (int d = 0; d < DIGITS; d++) begin
         if (digitAcc[4*d +: 4] >= 4'd5) begin
            adjusted[4*d +: 4] = digitAcc[4*d +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         magReg   <= '0;
         signReg  <= 1'b0;
         shReg    <= '0;
         digitAcc <= '0;
         iterCnt  <= '0;
      end else if (captureEn) begin
         magReg   <= bus.magnitude;
         signReg  <= bus.sign;
         shReg    <= bus.magnitude;
         digitAcc <= '0;
         iterCnt  <= '0;
      end else if (shiftEn) begin
         {digitAcc, shReg} <= {adjusted[4*DIGITS-2:0], shReg, 1'b0};
         iterCnt           <= iterCnt + CW'(1);
      end
   end

   // A zero magnitude never reports a minus sign, whatever the operand signs were.
   assign effSign = signReg & (magReg != '0);
   assign zeroExt = {1'b0, magReg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         doneReg   <= 1'b0;
         resultReg <= '0;
         negReg    <= 1'b0;
         bcdReg    <= '0;
      end else begin
         doneReg <= finishEn;
         if (finishEn) begin
            resultReg <= effSign ? (~zeroExt + (WIDTH+1)'(1)) : zeroExt;
            negReg    <= effSign;
            bcdReg    <= digitAcc;
         end
      end
   end

   assign bus.busy         = (stateReg != IDLE);
   assign bus.done         = doneReg;
   assign bus.signedResult = resultReg;
   assign bus.negative     = negReg;
   assign bus.bcd          = bcdReg;

endmodule
